// File: rtl/sine_width_gen.sv
`default_nettype none
// ============================================================================
// Module   : sine_width_gen
// Brief    : Phase-accumulated quarter-wave sine LUT mapped to a PWM duty
//            width through a four-stage pipeline (fold, LUT, offset, scale).
// Revision : 1.0
// ============================================================================

module sine_width_gen #(
    parameter int PERIOD  = 1000,
    parameter int PHASE_W = 32,
    parameter int LUT_AW  = 8,
    parameter int AMP_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               tick,
    input  logic [PHASE_W-1:0] fcw,
    output logic [31:0]        width,
    output logic               width_valid,
    output logic               overrun
);

    localparam int                 c_lut_depth = 1 << LUT_AW;
    localparam int                 c_prod_w    = AMP_W + 25;
    localparam logic [24:0]        c_period    = 25'(PERIOD);
    localparam logic [31:0]        c_width_rst = 32'(PERIOD / 2);
    localparam logic [AMP_W-1:0]   c_half      = {1'b1, {(AMP_W-1){1'b0}}};
    localparam logic [AMP_W-1:0]   c_half_m1   = {1'b0, {(AMP_W-1){1'b1}}};

    // Elaboration-time sine: a Taylor series is exact to double precision
    // over 0..pi/2, so the rounded table entries are deterministic.
    function automatic real sine_series(input real x);
        real term;
        real sum;
        term = x;
        sum  = x;
        for (int k = 1; k < 12; k++) begin
            term = -term * x * x / (real'(2 * k) * real'(2 * k + 1));
            sum  = sum + term;
        end
        return sum;
    endfunction

    function automatic logic [AMP_W-1:0] lut_entry(input int idx);
        real angle;
        real amp;
        angle = 3.14159265358979323846 / 2.0 * (real'(idx) + 0.5) / real'(c_lut_depth);
        amp   = real'((1 << (AMP_W - 1)) - 1);
        return AMP_W'($rtoi(amp * sine_series(angle) + 0.5));
    endfunction

    logic [AMP_W-1:0] w_lut [c_lut_depth];

    for (genvar gi = 0; gi < c_lut_depth; gi++) begin : g_lut
        localparam logic [AMP_W-1:0] c_entry = lut_entry(gi);
        assign w_lut[gi] = c_entry;
    end

    logic [PHASE_W-1:0]  r_phase;
    logic                r_v1;
    logic                r_v2;
    logic                r_v3;
    logic                r_neg1;
    logic                r_neg2;
    logic [LUT_AW-1:0]   r_addr1;
    logic [AMP_W-1:0]    r_mag2;
    logic [AMP_W-1:0]    r_u3;

    logic                w_busy;
    logic                w_accept;
    logic                w_drop;
    logic [LUT_AW-1:0]   w_idx;
    logic [LUT_AW-1:0]   w_addr;
    logic [AMP_W-1:0]    w_u;
    logic [c_prod_w-1:0] w_prod;
    logic [31:0]         w_width;

    // Busy spans the three internal stages plus the output cycle itself,
    // so a tick landing on the valid pulse is still treated as a collision.
    assign w_busy   = r_v1 | r_v2 | r_v3 | width_valid;
    assign w_accept = tick & en & ~w_busy;
    assign w_drop   = tick & en & w_busy;

    assign w_idx  = r_phase[PHASE_W-3 -: LUT_AW];
    assign w_addr = r_phase[PHASE_W-2] ? ~w_idx : w_idx;

    assign w_u     = r_neg2 ? (c_half_m1 - r_mag2) : (c_half + r_mag2);
    assign w_prod  = c_prod_w'(r_u3) * c_prod_w'(c_period);
    assign w_width = {7'b0, w_prod[AMP_W +: 25]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_phase     <= '0;
            r_v1        <= 1'b0;
            r_v2        <= 1'b0;
            r_v3        <= 1'b0;
            r_neg1      <= 1'b0;
            r_neg2      <= 1'b0;
            r_addr1     <= '0;
            r_mag2      <= '0;
            r_u3        <= '0;
            width       <= c_width_rst;
            width_valid <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            if (w_accept) begin
                r_phase <= r_phase + fcw;
                r_addr1 <= w_addr;
                r_neg1  <= r_phase[PHASE_W-1];
            end
            r_v1        <= w_accept;
            r_v2        <= r_v1;
            r_mag2      <= w_lut[r_addr1];
            r_neg2      <= r_neg1;
            r_v3        <= r_v2;
            r_u3        <= w_u;
            width_valid <= r_v3;
            if (r_v3) begin
                width <= w_width;
            end
            if (w_drop) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_sine_width_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_sine_width_gen
// Brief    : Self-checking bench for sine_width_gen against an arithmetic
//            sine/phase reference model.
// Revision : 1.0
// ============================================================================

module tb_sine_width_gen;

    localparam int PERIOD  = 1000;
    localparam int PHASE_W = 32;
    localparam int LUT_AW  = 8;
    localparam int AMP_W   = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        tick;
    logic [31:0] fcw;
    logic [31:0] width;
    logic        width_valid;
    logic        overrun;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] m_phase;
    logic        m_overrun;

    always #5 clk = ~clk;

    sine_width_gen #(
        .PERIOD  (PERIOD),
        .PHASE_W (PHASE_W),
        .LUT_AW  (LUT_AW),
        .AMP_W   (AMP_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .tick        (tick),
        .fcw         (fcw),
        .width       (width),
        .width_valid (width_valid),
        .overrun     (overrun)
    );

    // Reference: quarter number and in-quarter index from plain division,
    // sine from $sin, then offset and scale as integer arithmetic.
    function automatic int model_width(input logic [31:0] ph);
        int  quarter;
        int  idx;
        int  addr;
        int  mag;
        int  u;
        real ang;
        quarter = int'(ph / 32'h4000_0000);
        idx     = int'((ph / 32'd4194304) % 32'd256);
        addr    = (quarter % 2 == 1) ? (255 - idx) : idx;
        ang     = 3.14159265358979323846 / 2.0 * (real'(addr) + 0.5) / 256.0;
        mag     = int'($floor(32767.0 * $sin(ang) + 0.5));
        u       = (quarter >= 2) ? (32768 - 1 - mag) : (32768 + mag);
        return int'((longint'(u) * PERIOD) / 65536);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; tick = 1'b1; fcw = 32'h1234_5678;
        step();
        tick = 1'b0;
        step();
        step();
        rst = 1'b0;
        m_phase = '0; m_overrun = 1'b0;
        for (int i = 0; i < 20; i++) begin
            n_checks++;
            if (width !== 32'd500 || width_valid !== 1'b0 || overrun !== 1'b0)
                $display("FAIL reset_hold[%0d]: width=%0d valid=%b overrun=%b, expected 500/0/0",
                         i, width, width_valid, overrun);
            else n_pass++;
            step();
        end
    endtask

    task automatic test_sequence();
        int exp_tab [5] = '{501, 999, 498, 0, 501};
        fcw = 32'h4000_0000;
        for (int k = 0; k < 5; k++) begin
            tick = 1'b1;
            step();
            tick = 1'b0;
            step(); step(); step();
            n_checks++;
            if (width_valid !== 1'b1 || width !== 32'(exp_tab[k]))
                $display("FAIL sequence[%0d]: valid=%b width=%0d, expected 1/%0d",
                         k, width_valid, width, exp_tab[k]);
            else n_pass++;
            m_phase = m_phase + 32'h4000_0000;
            repeat (996) step();
        end
    endtask

    task automatic test_latency();
        logic [31:0] f;
        logic [31:0] prev;
        int          exp;
        f = $urandom; fcw = f; prev = width;
        exp = model_width(m_phase);
        m_phase = m_phase + f;
        tick = 1'b1;
        step();
        tick = 1'b0; en = 1'b0; fcw = $urandom;
        for (int c = 1; c < 4; c++) begin
            n_checks++;
            if (width_valid !== 1'b0 || width !== prev)
                $display("FAIL latency_early[N+%0d]: valid=%b width=%0d, expected 0/%0d",
                         c, width_valid, width, prev);
            else n_pass++;
            step();
        end
        n_checks++;
        if (width_valid !== 1'b1 || width !== 32'(exp))
            $display("FAIL latency_n4: valid=%b width=%0d, expected 1/%0d", width_valid, width, exp);
        else n_pass++;
        step();
        n_checks++;
        if (width_valid !== 1'b0 || width !== 32'(exp))
            $display("FAIL latency_n5: valid=%b width=%0d, expected 0/%0d", width_valid, width, exp);
        else n_pass++;
        en = 1'b1;
    endtask

    task automatic test_overrun();
        logic [31:0] f;
        int          exp;
        int          pulses;
        f = $urandom; fcw = f;
        exp = model_width(m_phase);
        tick = 1'b1;
        step();                       // N+1
        tick = 1'b0; fcw = $urandom;
        step();                       // N+2
        tick = 1'b1;
        step();                       // N+3
        tick = 1'b0;
        n_checks++;
        if (overrun !== 1'b1 || width_valid !== 1'b0)
            $display("FAIL overrun_n3: overrun=%b valid=%b, expected 1/0", overrun, width_valid);
        else n_pass++;
        step();                       // N+4
        n_checks++;
        if (width_valid !== 1'b1 || width !== 32'(exp))
            $display("FAIL overrun_n4: valid=%b width=%0d, expected 1/%0d", width_valid, width, exp);
        else n_pass++;
        m_phase = m_phase + f;
        m_overrun = 1'b1;
        pulses = 0;
        for (int c = 0; c < 8; c++) begin
            step();
            if (width_valid === 1'b1) pulses++;
        end
        n_checks++;
        if (pulses != 0 || overrun !== 1'b1)
            $display("FAIL overrun_after: extra_pulses=%0d overrun=%b, expected 0/1", pulses, overrun);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] f;
        int          exp1;
        int          exp2;
        f = $urandom; fcw = f;
        exp1 = model_width(m_phase);
        m_phase = m_phase + f;
        exp2 = model_width(m_phase);
        m_phase = m_phase + f;
        m_overrun = 1'b1;
        tick = 1'b1;
        step();
        tick = 1'b0;
        step(); step(); step();       // N+4
        n_checks++;
        if (width_valid !== 1'b1 || width !== 32'(exp1))
            $display("FAIL b2b_first: valid=%b width=%0d, expected 1/%0d", width_valid, width, exp1);
        else n_pass++;
        tick = 1'b1;                  // coincides with final stage: dropped
        step();                       // N+5, tick held: accepted
        step();                       // N+6
        tick = 1'b0;
        step(); step();               // N+8
        n_checks++;
        if (width_valid !== 1'b0 || width !== 32'(exp1))
            $display("FAIL b2b_dropped: valid=%b width=%0d, expected 0/%0d", width_valid, width, exp1);
        else n_pass++;
        step();                       // N+9
        n_checks++;
        if (width_valid !== 1'b1 || width !== 32'(exp2) || overrun !== 1'b1)
            $display("FAIL b2b_second: valid=%b width=%0d overrun=%b, expected 1/%0d/1",
                     width_valid, width, overrun, exp2);
        else n_pass++;
        step();
    endtask

    task automatic test_enable();
        logic [31:0] prev;
        logic [31:0] f;
        int          pulses;
        int          exp;
        en = 1'b0; prev = width; pulses = 0;
        for (int i = 0; i < 3; i++) begin
            fcw = $urandom;
            tick = 1'b1;
            step();
            tick = 1'b0;
            for (int c = 0; c < 6; c++) begin
                if (width_valid === 1'b1) pulses++;
                step();
            end
        end
        n_checks++;
        if (pulses != 0 || width !== prev || overrun !== m_overrun)
            $display("FAIL enable_off: pulses=%0d width=%0d overrun=%b, expected 0/%0d/%b",
                     pulses, width, overrun, prev, m_overrun);
        else n_pass++;
        en = 1'b1; f = $urandom; fcw = f;
        exp = model_width(m_phase);
        m_phase = m_phase + f;
        tick = 1'b1;
        step();
        tick = 1'b0;
        step(); step(); step();
        n_checks++;
        if (width_valid !== 1'b1 || width !== 32'(exp))
            $display("FAIL enable_resume: valid=%b width=%0d, expected 1/%0d", width_valid, width, exp);
        else n_pass++;
        step();
    endtask

    task automatic test_reset_mid();
        logic [31:0] f2;
        int          exp;
        fcw = $urandom;
        tick = 1'b1;
        step();                       // N+1
        tick = 1'b0;
        step();                       // N+2
        rst = 1'b1;
        step();                       // N+3: first cycle after reset
        rst = 1'b0;
        f2 = $urandom; fcw = f2;
        tick = 1'b1;
        m_phase = '0; m_overrun = 1'b0;
        for (int c = 3; c < 7; c++) begin
            n_checks++;
            if (width_valid !== 1'b0 || width !== 32'd500 || overrun !== 1'b0)
                $display("FAIL reset_mid[N+%0d]: valid=%b width=%0d overrun=%b, expected 0/500/0",
                         c, width_valid, width, overrun);
            else n_pass++;
            step();
            tick = 1'b0;
        end
        exp = model_width(32'd0);
        n_checks++;
        if (width_valid !== 1'b1 || width !== 32'(exp))
            $display("FAIL reset_restart: valid=%b width=%0d, expected 1/%0d", width_valid, width, exp);
        else n_pass++;
        m_phase = f2;
        step();
    endtask

    task automatic test_random();
        logic        en_now;
        logic        extra;
        int          d;
        int          exp;
        int          pulses;
        logic [31:0] f;
        logic [31:0] prev;
        for (int it = 0; it < 30; it++) begin
            repeat ($urandom_range(0, 5)) step();
            en_now = ($urandom_range(0, 3) != 0);
            extra  = ($urandom_range(0, 1) == 1);
            d      = $urandom_range(1, 4);
            f = $urandom; fcw = f; prev = width; en = en_now;
            tick = 1'b1;
            if (en_now) begin
                exp = model_width(m_phase);
                m_phase = m_phase + f;
                if (extra) m_overrun = 1'b1;
                for (int c = 1; c <= 4; c++) begin
                    step();
                    tick = extra && (c == d);
                    fcw = $urandom;
                    n_checks++;
                    if (c < 4) begin
                        if (width_valid !== 1'b0 || width !== prev)
                            $display("FAIL rand[%0d]_early: valid=%b width=%0d, expected 0/%0d",
                                     it, width_valid, width, prev);
                        else n_pass++;
                    end else begin
                        if (width_valid !== 1'b1 || width !== 32'(exp))
                            $display("FAIL rand[%0d]_valid: valid=%b width=%0d, expected 1/%0d",
                                     it, width_valid, width, exp);
                        else n_pass++;
                    end
                end
                step();
                tick = 1'b0;
                n_checks++;
                if (width_valid !== 1'b0 || width !== 32'(exp) || overrun !== m_overrun)
                    $display("FAIL rand[%0d]_after: valid=%b width=%0d overrun=%b, expected 0/%0d/%b",
                             it, width_valid, width, overrun, exp, m_overrun);
                else n_pass++;
            end else begin
                step();
                tick = 1'b0;
                pulses = 0;
                for (int c = 0; c < 5; c++) begin
                    if (width_valid === 1'b1) pulses++;
                    step();
                end
                n_checks++;
                if (pulses != 0 || width !== prev || overrun !== m_overrun)
                    $display("FAIL rand[%0d]_disabled: pulses=%0d width=%0d overrun=%b, expected 0/%0d/%b",
                             it, pulses, width, overrun, prev, m_overrun);
                else n_pass++;
            end
            en = 1'b1;
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; tick = 1'b0; fcw = '0;
        test_reset();
        test_sequence();
        test_latency();
        test_overrun();
        test_back_to_back();
        test_enable();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, passed=%0d checks=%0d", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire

// File: doc/sine_width_gen.md
SINE_WIDTH_GEN -- requirements
Module: sine_width_gen

Interface
REQ-001 Parameter PERIOD, default 1000: PWM period in clk cycles, the full-scale width; range 8..2^24.
REQ-002 Parameter PHASE_W, default 32: phase accumulator width.
REQ-003 Parameter LUT_AW, default 8: quarter-wave LUT address width (256 entries).
REQ-004 Parameter AMP_W, default 16: LUT sample and offset-code width.
REQ-005 Port clk, input, 1: single clock; all logic on its rising edge.
REQ-006 Port rst, input, 1: synchronous reset, active-high.
REQ-007 Port en, input, 1: active-high enable; when low, ticks are ignored.
REQ-008 Port tick, input, 1: one-cycle pulse marking a PWM period boundary.
REQ-009 Port fcw, input, PHASE_W: frequency control word, sampled on an accepted tick.
REQ-010 Port width, output, 32: registered duty width for the downstream PWM comparator.
REQ-011 Port width_valid, output, 1: one-cycle pulse, high in the cycle width takes a new value.
REQ-012 Port overrun, output, 1: sticky flag for a tick lost while the pipeline was busy.

Function
REQ-013 An accepted tick is tick=1 AND en=1 AND rst=0 AND pipeline idle.
REQ-014 On an accepted tick, the sample SHALL use the current phase, then phase <= phase + fcw (mod 2^PHASE_W).
REQ-015 Address fold: q = phase[PHASE_W-1:PHASE_W-2]; idx = next LUT_AW bits; addr = q[0] ? ~idx : idx.
REQ-016 LUT[i] = round((2^(AMP_W-1)-1) * sin(pi/2*(i+0.5)/2^LUT_AW)), read synchronously; LUT[0]=101 and LUT[255]=32767 at defaults.
REQ-017 Offset code: HALF = 2^(AMP_W-1); U = HALF + mag when q[1]=0, U = HALF - 1 - mag when q[1]=1; U lies in 0..2^AMP_W-1.
REQ-018 width = (U * PERIOD) >> AMP_W, truncated, zero-extended to 32 bits; range 0..PERIOD-1.
REQ-019 Pipeline: 4 stages (fold, LUT read, offset, scale); accepted tick at cycle N -> width updated and width_valid=1 at N+4.
REQ-020 The pipeline is busy from cycle N+1 through N+4 inclusive.
REQ-021 width SHALL hold its value between updates; it never changes without width_valid.
REQ-022 A tick with en=1 while the pipeline is busy SHALL be dropped: phase unchanged, no extra valid pulse, overrun <= 1 (sticky until rst).
REQ-023 A tick with en=0 SHALL have no effect: phase, width and overrun all hold.
REQ-024 en falling while the pipeline is busy SHALL NOT abort the in-flight sample; it completes at N+4.
REQ-025 A tick coincident with the final stage (N+4) SHALL be dropped per REQ-022; a tick at N+5 or later is accepted.
REQ-026 fcw changes take effect only at the next accepted tick.

Reset
REQ-027 When rst=1, the block SHALL set phase=0, width=PERIOD/2 (truncated), width_valid=0, overrun=0, and clear all pipeline valid bits.
REQ-028 Reset mid-pipeline SHALL flush the in-flight sample: no width_valid pulse and no width change for that sample.
REQ-029 A tick coincident with rst=1 SHALL be ignored.
REQ-030 The first tick in the cycle after rst deasserts SHALL be accepted.

Verification
REQ-031 Reset with defaults -> width=500, width_valid=0, overrun=0, held for 20 cycles with no tick.
REQ-032 fcw=0x4000_0000, four accepted ticks spaced 1000 cycles -> widths 501, 999, 498, 0 in order; fifth tick -> 501.
REQ-033 Latency: tick at cycle N -> width_valid=1 only at N+4; width changes in that cycle and not earlier.
REQ-034 Overrun: ticks at N and N+2 -> exactly one valid pulse (at N+4), overrun=1 from N+3 onward; phase advanced once.
REQ-035 en=0 during 3 ticks, then en=1 and a tick -> no pulses while disabled; the next sample continues the phase sequence unchanged.
REQ-036 Reset mid-pipeline: tick at N, rst at N+2 -> no width_valid at N+4; width=500, overrun=0; phase restarts at 0.
